// File: rtl/util_wr_sync_sched_pkg.sv
// Shared types for the timestamp write-sync scheduler: FSM states and default counter width.
// No logic; imported by the scheduler and its period counter.
package util_wr_sync_sched_pkg;

    localparam int DEF_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

endpackage

// File: rtl/util_wr_sync_period_cnt.sv
// Modulo-N sample counter: o_count runs 0..N-1, o_wrap is a same-cycle strobe on the last increment.
// One-cycle update latency; i_clr overrides counting and has no backpressure.
module util_wr_sync_period_cnt #(
    parameter int W = util_wr_sync_sched_pkg::DEF_COUNT_WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_period,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         w_last;

    // >= keeps the counter bounded even if the period shrinks below the current position
    assign w_last  = (r_count >= (i_period - W'(1)));
    assign o_wrap  = i_inc & w_last;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr || o_wrap) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/util_wr_sync_sched.sv
// Timestamp write-sync scheduler: requests a sync at samples 0, N, 2N..., held until sync_ack; request is registered (1 cycle).
// Single outstanding request; boundary with a pending request sets sticky overrun. UTIL_WR_SYNC_SCHED_STATS_EN enables sync_count.
module util_wr_sync_sched
    import util_wr_sync_sched_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] timestamp_every,
    input  logic                   sample_valid,
    input  logic                   sync_ack,
    output logic                   timestamp_wr_sync,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic [31:0]            sync_count
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [COUNT_WIDTH-1:0] r_period;
    logic                   r_sync;
    logic                   r_overrun;
    logic                   w_load;
    logic                   w_ovr_set;
    logic                   w_wrap;
    logic                   w_every_zero;

    assign w_every_zero = (timestamp_every == '0);

    util_wr_sync_period_cnt #(
        .W (COUNT_WIDTH)
    ) u_period_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (w_next_state == ST_IDLE),
        .i_inc    (sample_valid && (r_state != ST_IDLE)),
        .i_period (r_period),
        .o_count  (sample_count),
        .o_wrap   (w_wrap)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_every_zero) begin
                    w_next_state = ST_REQ;
                    w_load       = 1'b1;
                end
            end
            ST_REQ: begin
                // a boundary re-issues the request whether or not this cycle's ack consumed the old one
                if (w_wrap) begin
                    w_load = 1'b1;
                    if (w_every_zero) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_REQ;
                        w_ovr_set    = !sync_ack;
                    end
                end else if (sync_ack) begin
                    w_next_state = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_wrap) begin
                    w_load       = 1'b1;
                    w_next_state = w_every_zero ? ST_IDLE : ST_REQ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (!enable) begin
            w_next_state = ST_IDLE;
            w_load       = 1'b0;
            w_ovr_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_sync    <= 1'b0;
            r_period  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_sync  <= (w_next_state == ST_REQ);
            if (w_load) begin
                r_period <= timestamp_every;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign timestamp_wr_sync = r_sync;
    assign overrun           = r_overrun;

`ifdef UTIL_WR_SYNC_SCHED_STATS_EN
    logic        w_ack_take;
    logic [31:0] r_sync_count;

    assign w_ack_take = enable && (r_state == ST_REQ) && sync_ack;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync_count <= 32'd0;
        end else if (w_ack_take) begin
            r_sync_count <= r_sync_count + 32'd1;
        end
    end

    assign sync_count = r_sync_count;
`else
    assign sync_count = 32'd0;
`endif

endmodule
